tx_stream_arbiter: RTL



---
 rtl/pcie_tx_pkg.sv | 43 ++++
 rtl/skp_timer.sv | 51 +++++
 rtl/tx_stream_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pcie_tx_pkg.sv
// pcie_tx_pkg: shared types and defaults for the PIPE TX stream arbiter.
// Holds the tx_sel encoding, ordered-set type encoding, the arbiter state
// enum, default timing constants and small mapping helpers.
package pcie_tx_pkg;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_DATA = 2'd1,
      TX_OS   = 2'd2,
      TX_SKP  = 2'd3
   } tx_sel_t;

   typedef enum logic [1:0] {
      OS_TS1  = 2'd0,
      OS_TS2  = 2'd1,
      OS_EIOS = 2'd2,
      OS_RSVD = 2'd3
   } os_type_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_OS   = 2'd2,
      ST_SKP  = 2'd3
   } arb_state_t;

   localparam int SKP_INTERVAL_DEF = 1180;
   localparam int OS_LEN_DEF       = 4;
   localparam int SKP_LEN_DEF      = 1;
   localparam logic [1:0] SKP_PENDING_MAX = 2'd3;

   // The reserved ordered-set code is transmitted as TS1.
   function automatic os_type_t norm_os_type(input logic [1:0] t);
      return (t == OS_RSVD) ? OS_TS1 : os_type_t'(t);
   endfunction

   function automatic tx_sel_t state_to_sel(input arb_state_t s);
      return (s == ST_DATA) ? TX_DATA :
             (s == ST_OS)   ? TX_OS   :
             (s == ST_SKP)  ? TX_SKP  : TX_IDLE;
   endfunction

endpackage

// File: rtl/skp_timer.sv
// skp_timer: SKP interval counter with a saturating pending-SKP count.
// Ports: clk/rst_n (async active-low), i_hold clears counter and pending
// (electrical idle), i_consume marks the last cycle of a sent SKP,
// o_pending is the queued SKP count, o_overflow is sticky once an interval
// event is dropped at saturation.
module skp_timer
   import pcie_tx_pkg::*;
#(
   parameter int SKP_INTERVAL = SKP_INTERVAL_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_hold,
   input  logic       i_consume,
   output logic [1:0] o_pending,
   output logic       o_overflow
);

   localparam int CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_pending;
   logic          r_overflow;
   logic          w_wrap;

   assign w_wrap     = (r_cnt == CW'(SKP_INTERVAL - 1));
   assign o_pending  = r_pending;
   assign o_overflow = r_overflow;

   // A wrap and a consume in the same cycle cancel out, so neither the
   // count nor the overflow flag moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else if (i_hold) begin
         r_cnt     <= '0;
         r_pending <= '0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
         if (w_wrap && !i_consume) begin
            if (r_pending == SKP_PENDING_MAX) r_overflow <= 1'b1;
            else r_pending <= r_pending + 2'd1;
         end else if (i_consume && !w_wrap && r_pending != 2'd0) begin
            r_pending <= r_pending - 2'd1;
         end
      end
   end

endmodule

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: per-link PIPE TX scheduler choosing between SKP ordered
// sets, LTSSM ordered sets and LPIF data, never splitting a packet or an OS.
// Ports: clk/rst_n (async active-low); i_tx_elec_idle holds the SKP timer and
// parks the arbiter; i_link_active enables data grants; i_os_req/i_os_type
// request an ordered set, acknowledged by o_os_gnt (first cycle) and o_os_done
// (last cycle); i_data_irdy/i_data_eop/o_data_trdy form the data handshake;
// o_tx_sel selects the lane source, o_os_sel_type is the latched OS type,
// o_os_word_idx the cycle index inside an OS/SKP; o_skp_sent pulses on the
// last SKP cycle; o_skp_pending/o_skp_overflow expose the SKP timer.
module tx_stream_arbiter
   import pcie_tx_pkg::*;
#(
   parameter int SKP_INTERVAL = SKP_INTERVAL_DEF,
   parameter int OS_LEN       = OS_LEN_DEF,
   parameter int SKP_LEN      = SKP_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tx_elec_idle,
   input  logic       i_link_active,
   input  logic       i_os_req,
   input  logic [1:0] i_os_type,
   output logic       o_os_gnt,
   output logic       o_os_done,
   input  logic       i_data_irdy,
   input  logic       i_data_eop,
   output logic       o_data_trdy,
   output logic [1:0] o_tx_sel,
   output logic [1:0] o_os_sel_type,
   output logic [1:0] o_os_word_idx,
   output logic       o_skp_sent,
   output logic [1:0] o_skp_pending,
   output logic       o_skp_overflow
);

   localparam logic [1:0] OS_LAST  = 2'(OS_LEN - 1);
   localparam logic [1:0] SKP_LAST = 2'(SKP_LEN - 1);

   arb_state_t r_state;
   tx_sel_t    r_tx_sel;
   os_type_t   r_sel_type;
   logic [1:0] r_idx;
   logic       r_gnt;
   logic       r_done;
   logic       r_sent;

   arb_state_t w_next;
   logic [1:0] w_pending;
   logic [1:0] w_idx_inc;
   logic       w_overflow;
   logic       w_last_os;
   logic       w_last_skp;
   logic       w_eop_xfer;
   logic       w_arb;
   logic       w_skp_due;

   skp_timer #(
      .SKP_INTERVAL(SKP_INTERVAL)
   ) u_skp_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_hold    (i_tx_elec_idle),
      .i_consume (w_last_skp),
      .o_pending (w_pending),
      .o_overflow(w_overflow)
   );

   assign o_data_trdy = (r_state == ST_DATA) && i_link_active;
   assign w_last_os   = (r_state == ST_OS) && (r_idx == OS_LAST);
   assign w_last_skp  = (r_state == ST_SKP) && (r_idx == SKP_LAST);
   assign w_eop_xfer  = i_data_irdy && i_data_eop && o_data_trdy;
   assign w_arb       = (r_state == ST_IDLE) || w_eop_xfer || w_last_os || w_last_skp;
   assign w_idx_inc   = r_idx + 2'd1;

   // The SKP finishing this cycle is already counted in pending, so it must
   // not re-trigger another SKP by itself.
   assign w_skp_due = w_pending > {1'b0, w_last_skp};

   assign w_next = i_tx_elec_idle                ? ST_IDLE :
                   w_skp_due                     ? ST_SKP  :
                   i_os_req                      ? ST_OS   :
                   (i_link_active && i_data_irdy) ? ST_DATA : ST_IDLE;

   // Outputs are computed for the next cycle together with the state, so
   // every output except trdy is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_tx_sel   <= TX_IDLE;
         r_sel_type <= OS_TS1;
         r_idx      <= '0;
         r_gnt      <= 1'b0;
         r_done     <= 1'b0;
         r_sent     <= 1'b0;
      end else if (w_arb) begin
         r_state  <= w_next;
         r_tx_sel <= state_to_sel(w_next);
         r_idx    <= '0;
         r_gnt    <= (w_next == ST_OS);
         r_done   <= (w_next == ST_OS) && (OS_LAST == 2'd0);
         r_sent   <= (w_next == ST_SKP) && (SKP_LAST == 2'd0);
         if (w_next == ST_OS) r_sel_type <= norm_os_type(i_os_type);
      end else begin
         r_idx  <= (r_state == ST_OS || r_state == ST_SKP) ? w_idx_inc : '0;
         r_gnt  <= 1'b0;
         r_done <= (r_state == ST_OS) && (w_idx_inc == OS_LAST);
         r_sent <= (r_state == ST_SKP) && (w_idx_inc == SKP_LAST);
      end
   end

   assign o_tx_sel       = r_tx_sel;
   assign o_os_sel_type  = r_sel_type;
   assign o_os_word_idx  = r_idx;
   assign o_os_gnt       = r_gnt;
   assign o_os_done      = r_done;
   assign o_skp_sent     = r_sent;
   assign o_skp_pending  = w_pending;
   assign o_skp_overflow = w_overflow;

endmodule
